mem_refill_arbiter: RTL
=======================

// Module: mem_refill_arbiter
// PURPOSE
//  Shared backing-memory port between ICache miss refill and DCache refill/write-back.
//  Sits downstream of i_cache/d_cache, replacing their direct IMemory hookup.
//  Serialises line transactions, models a fixed LATENCY access time and returns one-cycle ready pulses.
//  Alternates grants between the two caches so neither starves.
// PARAMETERS
//  ADDR_W   32   line-address width (word address >> 2 of the line base)
//  LINE_W   128  cache-line width in bits
//  LATENCY  4    memory access cycles per transaction; legal range 1..15
// PORTS
//  clock      in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  ic_req     in   1       ICache line read request; held until ic_ready
//  ic_addr    in   ADDR_W  ICache line address
//  ic_ready   out  1       one-cycle pulse: ic_rdata valid
//  ic_rdata   out  LINE_W  returned ICache line
//  dc_req     in   1       DCache request; held until dc_ready
//  dc_we      in   1       1 = line write-back, 0 = line read
//  dc_addr    in   ADDR_W  DCache line address
//  dc_wdata   in   LINE_W  write-back line
//  dc_ready   out  1       one-cycle pulse: read data valid / write done
//  dc_rdata   out  LINE_W  returned DCache line
//  mem_en     out  1       backing-memory access active
//  mem_we     out  1       write strobe; memory writes on the clock edge where mem_en & mem_we
//  mem_addr   out  ADDR_W  latched transaction address
//  mem_wdata  out  LINE_W  latched write data
//  mem_rdata  in   LINE_W  memory read data, combinational from mem_addr
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset (async, immediate):
//   - state = IDLE; every output = 0.
//   - last_grant = IC, so the first tie goes to DC.
//  FSM IDLE -> ACCESS -> RESP -> IDLE:
//   - IDLE: at an edge with any req high, choose the winner and latch its addr/we/wdata.
//     Set cnt = LATENCY-1 and go to ACCESS.
//   - Winner: the single requester if only one is high.
//     If both are high, the requester != last_grant; update last_grant to the winner.
//   - ACCESS: mem_en = 1.
//     If cnt != 0, decrement at each edge.
//     If cnt == 0, at that edge capture mem_rdata into the winner's rdata (reads only) and go to RESP.
//   - mem_we = 1 only in the ACCESS cycle with cnt == 0 and latched we = 1.
//     Exactly one write per write-back.
//   - RESP: winner's ready = 1 for exactly this cycle; mem_en = 0. Next edge goes to IDLE.
//   - IDLE is not skipped: ready falls before the next accept, so the next req is sampled only after the requester has seen ready.
//  Latency:
//   - req first high in cycle c with FSM in IDLE -> ready high in cycle c+LATENCY+1.
//   - Back-to-back transactions are LATENCY+2 cycles apart.
//  Data hold:
//   - ic_rdata/dc_rdata hold their last captured line until the next read for that port.
//   - A DC write leaves dc_rdata unchanged.
//  Requester rules and ignored inputs:
//   - Addr/we/wdata are latched at accept, so changes during ACCESS are ignored.
//   - A req dropped mid-transaction does not abort it; the ready pulse still occurs.
//   - The losing requester keeps req high and is accepted in the first IDLE cycle after the RESP.
//  LATENCY = 1: ACCESS lasts one cycle (cnt loads 0).
//  Reset mid-transaction:
//   - Abort to IDLE with no ready pulse.
//   - No mem_we if reset arrives before the cnt == 0 edge.
//   - A req still high after release is served from scratch with full latency.
// TESTING
//  1. Assert reset between edges during ACCESS -> mem_en, busy and all readys go 0 at once; no write-back occurs.
//  2. LATENCY=4, ic_req=1, ic_addr=0x10, memory line 0xA5A5..A5 -> ic_ready only in cycle c+5; ic_rdata=0xA5A5..A5.
//  3. DC write 0x20 with 0x0123..CDEF, then DC read 0x20 -> exactly one mem_we cycle; the read returns 0x0123..CDEF.
//  4. ic_req and dc_req rise together after reset and stay high -> grant order DC, IC, DC, IC; grants are 6 cycles apart.
//  5. Reset during ACCESS with ic_req held -> no ic_ready before reset; ic_ready at release+LATENCY+1 with the correct line.
//  6. LATENCY=1, DC reads streaming 0x0..0x7 -> 8 dc_ready pulses 3 cycles apart, each with data for its own address.

Source files
------------

// File: rtl/mem_refill_arbiter_if.sv
// Bus bundle between the refill arbiter, the two cache refill ports and the
// backing memory.
//
// Handshake: a cache raises *_req with a stable request and holds it until it
// sees *_ready. *_ready is a single-cycle pulse; for reads the matching
// *_rdata is valid in that cycle and stays unchanged until the next read on
// that port. The arbiter latches the request fields when it accepts, so they
// may change freely once the transaction has started.
interface mem_refill_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_ready;
    logic [LINE_W-1:0] ic_rdata;

    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [LINE_W-1:0] dc_wdata;
    logic              dc_ready;
    logic [LINE_W-1:0] dc_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
        output ic_ready, ic_rdata, dc_ready, dc_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // Cache and memory side.
    modport master (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
        input  ic_ready, ic_rdata, dc_ready, dc_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_refill_arbiter.sv
// Shared backing-memory port for ICache refill and DCache refill/write-back.
// One line transaction at a time: IDLE -> ACCESS (LATENCY cycles) -> RESP.
// Ties alternate between the caches; the first tie after reset goes to DC.
module mem_refill_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int LATENCY = 4      // 1..15
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_refill_arbiter_if.slave  bus,
    output logic                 busy,
    output logic [1:0]           dbgState
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic [3:0]        cnt;
    logic              grantDc;      // current transaction belongs to DC
    logic              lastGrantDc;  // most recent grant went to DC
    logic              weQ;
    logic [ADDR_W-1:0] addrQ;
    logic [LINE_W-1:0] wdataQ;
    logic [LINE_W-1:0] icRdataQ;
    logic [LINE_W-1:0] dcRdataQ;
    logic              accept;
    logic              pickDc;
    logic              capture;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state, arbitration decision and per-state strobes.
    always_comb begin
        stateNext    = state;
        accept       = 1'b0;
        pickDc       = 1'b0;
        capture      = 1'b0;
        bus.mem_en   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.ic_ready = 1'b0;
        bus.dc_ready = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ic_req || bus.dc_req) begin
                    accept    = 1'b1;
                    // On a tie the cache that did not win last time goes first.
                    pickDc    = bus.dc_req && (!bus.ic_req || !lastGrantDc);
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_en = 1'b1;
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    bus.mem_we = weQ;
                    stateNext  = RESP;
                end
            end
            RESP: begin
                bus.ic_ready = !grantDc;
                bus.dc_ready = grantDc;
                stateNext    = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Transaction latch, access countdown and read-data capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= 4'd0;
            grantDc     <= 1'b0;
            lastGrantDc <= 1'b0;
            weQ         <= 1'b0;
            addrQ       <= '0;
            wdataQ      <= '0;
            icRdataQ    <= '0;
            dcRdataQ    <= '0;
        end else begin
            if (accept) begin
                grantDc     <= pickDc;
                lastGrantDc <= pickDc;
                weQ         <= pickDc && bus.dc_we;
                addrQ       <= pickDc ? bus.dc_addr : bus.ic_addr;
                if (pickDc) begin
                    wdataQ <= bus.dc_wdata;
                end
                cnt <= 4'(LATENCY - 1);
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // Write-backs leave dc_rdata alone.
            if (capture && !weQ) begin
                if (grantDc) begin
                    dcRdataQ <= bus.mem_rdata;
                end else begin
                    icRdataQ <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_addr  = addrQ;
    assign bus.mem_wdata = wdataQ;
    assign bus.ic_rdata  = icRdataQ;
    assign bus.dc_rdata  = dcRdataQ;
    assign busy          = (state != IDLE);
    assign dbgState      = state;

endmodule
